// File: rtl/mask_clear_array.sv
`default_nettype none
// mask_clear_array: set-indexed storage with per-lane write masks, lane-accurate
// read-during-write bypass and a self-sequenced init sweep after reset or clear.
module mask_clear_array #(
  parameter int                s_index  = 3,
  parameter int                width    = 32,
  parameter int                gran     = 8,
  parameter int                num_sets = 2**s_index,
  parameter int                nlanes   = width/gran,
  parameter logic [width-1:0]  init_val = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                read,
  input  logic                load,
  input  logic [s_index-1:0]  rindex,
  input  logic [s_index-1:0]  windex,
  input  logic [nlanes-1:0]   wmask,
  input  logic [width-1:0]    datain,
  input  logic                clear,
  output logic [width-1:0]    dataout,
  output logic                busy
);

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  localparam logic [s_index-1:0] last_set = s_index'(num_sets - 1);

  state_t             state, state_next;
  logic [s_index-1:0] ptr, ptr_next;
  logic [width-1:0]   data [num_sets];

  logic               accept;
  logic               wr_en;
  logic [s_index-1:0] wr_addr;
  logic [width-1:0]   wr_data;
  logic [nlanes-1:0]  wr_lanes;
  logic [width-1:0]   rd_merged;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // The sweep and user writes share one write port; the sweep owns it while busy.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    accept     = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = windex;
    wr_data    = datain;
    wr_lanes   = wmask;
    if (state == CLEAR) begin
      wr_en    = 1'b1;
      wr_addr  = ptr;
      wr_data  = init_val;
      wr_lanes = '1;
      ptr_next = ptr + 1'b1;
      if (ptr == last_set) begin
        state_next = IDLE;
      end
    end else begin
      if (clear) begin
        state_next = CLEAR;
        ptr_next   = '0;
      end else begin
        accept = 1'b1;
        wr_en  = load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      for (int i = 0; i < nlanes; i++) begin
        if (wr_lanes[i]) begin
          data[wr_addr][i*gran +: gran] <= wr_data[i*gran +: gran];
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < nlanes; g++) begin : g_lane
      assign rd_merged[g*gran +: gran] = (load && (windex == rindex) && wmask[g])
                                         ? datain[g*gran +: gran]
                                         : data[rindex][g*gran +: gran];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dataout <= '0;
    end else if (accept && read) begin
      dataout <= rd_merged;
    end
  end

  assign busy = (state == CLEAR);

endmodule
`default_nettype wire
